// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I external memory bridge:
// CPU access codes, funct3 size codes, defaults and the bridge state encoding.
package rv32i_pkg;

    localparam logic [1:0] ACC_READ  = 2'd0;
    localparam logic [1:0] ACC_WRITE = 2'd1;
    localparam logic [1:0] ACC_CODE  = 2'd2;
    localparam logic [1:0] ACC_NONE  = 2'd3;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0]  LOCAL_TADDR_DEF = 4'h1;
    localparam logic [31:0] RD_TIMEOUT_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } bridge_state_e;

endpackage

// File: rtl/rv32i_bus_lanes.sv
// Byte-lane steering: store replication and byte enables from the live CPU request,
// load shift and sign/zero extension from the latched request.
module rv32i_bus_lanes
    import rv32i_pkg::*;
(
    input  logic [1:0]  wr_addr_lo,
    input  logic [2:0]  wr_ctrl,
    input  logic [31:0] wr_data,
    input  logic [1:0]  rd_addr_lo,
    input  logic [2:0]  rd_ctrl,
    input  logic [31:0] rd_data,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_fmt
);

    logic [4:0]  rd_shamt;
    logic [31:0] rd_shifted;

    always_comb begin
        be        = 4'b1111;
        wdata_rep = wr_data;
        case (wr_ctrl)
            F3_B, F3_BU: begin
                be        = 4'b0001 << wr_addr_lo;
                wdata_rep = {4{wr_data[7:0]}};
            end
            F3_H, F3_HU: begin
                be        = 4'b0011 << {wr_addr_lo[1], 1'b0};
                wdata_rep = {2{wr_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Halfwords ignore addr[0] and words ignore addr[1:0]; misalignment is not trapped.
    always_comb begin
        rd_shamt = 5'd0;
        case (rd_ctrl)
            F3_B, F3_BU: rd_shamt = {rd_addr_lo, 3'b000};
            F3_H, F3_HU: rd_shamt = {rd_addr_lo[1], 4'b0000};
            default:     rd_shamt = 5'd0;
        endcase
    end

    assign rd_shifted = rd_data >> rd_shamt;

    always_comb begin
        rdata_fmt = rd_shifted;
        case (rd_ctrl)
            F3_B:    rdata_fmt = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            F3_H:    rdata_fmt = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            F3_BU:   rdata_fmt = {24'h000000, rd_shifted[7:0]};
            F3_HU:   rdata_fmt = {16'h0000, rd_shifted[15:0]};
            default: rdata_fmt = rd_shifted;
        endcase
    end

endmodule

// File: rtl/rv32i_mem_bridge.sv
// Stalls the CPU on non-local loads/stores and runs one valid/ready bus transaction,
// returning formatted load data; a wait counter forces completion if the slave never answers.
module rv32i_mem_bridge
    import rv32i_pkg::*;
#(
    parameter logic [3:0]  LOCAL_TADDR = LOCAL_TADDR_DEF,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] w_mic_addr,
    input  logic [31:0] w_mic_wdata,
    input  logic [2:0]  w_mic_ctrl,
    input  logic [1:0]  w_mic_req,
    output logic        w_stall,
    output logic [31:0] w_data,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic        w_err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    bridge_state_e state, state_next;
    logic [CW-1:0] wait_cnt;
    logic [2:0]    ctrl_q;
    logic [1:0]    addr_lo_q;
    logic          ldst_req;
    logic          ext_req;
    logic          timeout_hit;
    logic [3:0]    lane_be;
    logic [31:0]   lane_wdata;
    logic [31:0]   lane_rdata;

    assign ldst_req    = (w_mic_req == ACC_READ) || (w_mic_req == ACC_WRITE);
    assign ext_req     = ldst_req && (w_mic_addr[31:28] != LOCAL_TADDR);
    assign w_stall     = ext_req && (state != ST_DONE);
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CW'(TIMEOUT));

    rv32i_bus_lanes u_lanes (
        .wr_addr_lo (w_mic_addr[1:0]),
        .wr_ctrl    (w_mic_ctrl),
        .wr_data    (w_mic_wdata),
        .rd_addr_lo (addr_lo_q),
        .rd_ctrl    (ctrl_q),
        .rd_data    (bus_rdata),
        .be         (lane_be),
        .wdata_rep  (lane_wdata),
        .rdata_fmt  (lane_rdata)
    );

    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (ext_req) state_next = ST_REQ;
            ST_REQ:  if (bus_ready || timeout_hit) state_next = ST_DONE;
            ST_DONE: if (!ldst_req) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bus_valid <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            w_data    <= '0;
            w_err     <= 1'b0;
            wait_cnt  <= '0;
            ctrl_q    <= '0;
            addr_lo_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ext_req) begin
                        bus_valid <= 1'b1;
                        bus_we    <= (w_mic_req == ACC_WRITE);
                        bus_addr  <= {w_mic_addr[31:2], 2'b00};
                        bus_be    <= lane_be;
                        bus_wdata <= lane_wdata;
                        ctrl_q    <= w_mic_ctrl;
                        addr_lo_q <= w_mic_addr[1:0];
                        wait_cnt  <= '0;
                    end
                end
                ST_REQ: begin
                    if (bus_ready) begin
                        bus_valid <= 1'b0;
                        if (!bus_we) w_data <= lane_rdata;
                    end else if (timeout_hit) begin
                        // A timed-out write is simply dropped; a read returns a marker pattern.
                        bus_valid <= 1'b0;
                        w_err     <= 1'b1;
                        if (!bus_we) w_data <= RD_TIMEOUT_DATA;
                    end else if (TIMEOUT != 0) begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_mem_bridge.sv
// Directed bench for rv32i_mem_bridge: stores, loads, local/fetch bypass, timeout and reset abort.
module tb_rv32i_mem_bridge;
    import rv32i_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] w_mic_addr;
    logic [31:0] w_mic_wdata;
    logic [2:0]  w_mic_ctrl;
    logic [1:0]  w_mic_req;
    logic        w_stall;
    logic [31:0] w_data;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        w_err;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    rv32i_mem_bridge #(.LOCAL_TADDR(4'h1), .TIMEOUT(4)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .w_mic_addr  (w_mic_addr),
        .w_mic_wdata (w_mic_wdata),
        .w_mic_ctrl  (w_mic_ctrl),
        .w_mic_req   (w_mic_req),
        .w_stall     (w_stall),
        .w_data      (w_data),
        .bus_valid   (bus_valid),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_be      (bus_be),
        .bus_wdata   (bus_wdata),
        .bus_ready   (bus_ready),
        .bus_rdata   (bus_rdata),
        .w_err       (w_err)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drives one CPU access and a slave that answers after 'waits' valid cycles.
    // Returns observations only; the calling test does the comparisons.
    task automatic do_access(
        input  logic [1:0]  req,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  logic [2:0]  ctrl,
        input  int          waits,
        input  logic [31:0] rdata,
        output int          stalls,
        output logic [31:0] got_addr,
        output logic [3:0]  got_be,
        output logic [31:0] got_wdata,
        output logic        got_we,
        output bit          unstable,
        output logic        valid_after,
        output logic [31:0] ma_data,
        output bit          hung
    );
        int vcnt;
        bit seen;
        stalls = 0; vcnt = 0; seen = 0; unstable = 0; hung = 1;
        got_addr = '0; got_be = '0; got_wdata = '0; got_we = 1'b0;
        w_mic_req = req; w_mic_addr = addr; w_mic_wdata = wdata; w_mic_ctrl = ctrl;
        bus_ready = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!w_stall) begin
                hung = 0;
                break;
            end
            stalls++;
            if (bus_valid) begin
                if (seen && (bus_addr !== got_addr || bus_be !== got_be ||
                             bus_wdata !== got_wdata || bus_we !== got_we))
                    unstable = 1;
                got_addr = bus_addr; got_be = bus_be; got_wdata = bus_wdata; got_we = bus_we;
                seen = 1;
                bus_ready = (vcnt == waits);
                bus_rdata = (vcnt == waits) ? rdata : 32'h5A5A0F0F;
                vcnt++;
            end
            @(posedge CLK);
            #1;
            bus_ready = 1'b0;
        end
        valid_after = bus_valid;
        tick();
        w_mic_req = ACC_NONE;
        #1;
        ma_data = w_data;
        tick();
    endtask

    int          st;
    logic [31:0] ga, gw, md;
    logic [3:0]  gb;
    logic        gwe, va;
    bit          us, hg;

    task automatic test_reset();
        RST = 1'b1; bus_ready = 1'b0; bus_rdata = '0;
        w_mic_req = ACC_NONE; w_mic_addr = '0; w_mic_wdata = '0; w_mic_ctrl = F3_W;
        repeat (3) tick();
        checks++;
        if ({bus_valid, bus_we, bus_be} !== 6'b0) begin
            errors++; $display("FAIL reset_ctl got %b exp 000000", {bus_valid, bus_we, bus_be});
        end
        checks++;
        if (bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_bus got addr %h wdata %h exp 0", bus_addr, bus_wdata);
        end
        checks++;
        if (w_data !== 32'h0 || w_err !== 1'b0) begin
            errors++; $display("FAIL reset_data got %h err %b exp 0", w_data, w_err);
        end
        w_mic_req = ACC_READ; w_mic_addr = 32'h20000000;
        #1;
        checks++;
        if (w_stall !== 1'b1) begin
            errors++; $display("FAIL reset_stall_comb got %b exp 1", w_stall);
        end
        tick();
        checks++;
        if (bus_valid !== 1'b0) begin
            errors++; $display("FAIL reset_hold_valid got %b exp 0", bus_valid);
        end
        w_mic_req = ACC_NONE; RST = 1'b0;
        tick();
    endtask

    task automatic test_stores();
        do_access(ACC_WRITE, 32'h20000003, 32'h000000A5, F3_B, 0, 32'h0,
                  st, ga, gb, gw, gwe, us, va, md, hg);
        checks++;
        if (st !== 2 || hg) begin errors++; $display("FAIL sb_stall got %0d exp 2", st); end
        checks++;
        if (ga !== 32'h20000000 || gb !== 4'b1000) begin
            errors++; $display("FAIL sb_addr_be got %h %b exp 20000000 1000", ga, gb);
        end
        checks++;
        if (gw !== 32'hA5A5A5A5 || gwe !== 1'b1) begin
            errors++; $display("FAIL sb_wdata got %h we %b exp a5a5a5a5 1", gw, gwe);
        end
        checks++;
        if (va !== 1'b0) begin errors++; $display("FAIL sb_valid_drop got %b exp 0", va); end
        checks++;
        if (md !== 32'h0) begin errors++; $display("FAIL sb_wdata_untouched got %h exp 0", md); end

        do_access(ACC_WRITE, 32'h20000006, 32'h5555C3D2, F3_H, 1, 32'h0,
                  st, ga, gb, gw, gwe, us, va, md, hg);
        checks++;
        if (ga !== 32'h20000004 || gb !== 4'b1100 || gw !== 32'hC3D2C3D2 || st !== 3) begin
            errors++; $display("FAIL sh_lanes got %h %b %h st %0d exp 20000004 1100 c3d2c3d2 3", ga, gb, gw, st);
        end
        checks++;
        if (us) begin errors++; $display("FAIL sh_stable got unstable exp stable"); end

        do_access(ACC_WRITE, 32'h2000000B, 32'h11223344, F3_W, 0, 32'h0,
                  st, ga, gb, gw, gwe, us, va, md, hg);
        checks++;
        if (ga !== 32'h20000008 || gb !== 4'b1111 || gw !== 32'h11223344) begin
            errors++; $display("FAIL sw_lanes got %h %b %h exp 20000008 1111 11223344", ga, gb, gw);
        end
    endtask

    task automatic test_loads();
        do_access(ACC_READ, 32'h20000002, 32'h0, F3_H, 3, 32'h80011234,
                  st, ga, gb, gw, gwe, us, va, md, hg);
        checks++;
        if (st !== 5 || hg) begin errors++; $display("FAIL lh_stall got %0d exp 5", st); end
        checks++;
        if (md !== 32'hFFFF8001) begin errors++; $display("FAIL lh_data got %h exp ffff8001", md); end
        checks++;
        if (gb !== 4'b1100 || gwe !== 1'b0 || ga !== 32'h20000000) begin
            errors++; $display("FAIL lh_req got %h %b we %b exp 20000000 1100 0", ga, gb, gwe);
        end
        checks++;
        if (us) begin errors++; $display("FAIL lh_stable got unstable exp stable"); end

        do_access(ACC_READ, 32'h20000001, 32'h0, F3_BU, 0, 32'h0000F000,
                  st, ga, gb, gw, gwe, us, va, md, hg);
        checks++;
        if (md !== 32'h000000F0 || gb !== 4'b0010) begin
            errors++; $display("FAIL lbu_data got %h be %b exp 000000f0 0010", md, gb);
        end

        do_access(ACC_READ, 32'h20000001, 32'h0, F3_B, 0, 32'h0000F000,
                  st, ga, gb, gw, gwe, us, va, md, hg);
        checks++;
        if (md !== 32'hFFFFFFF0) begin errors++; $display("FAIL lb_data got %h exp fffffff0", md); end

        do_access(ACC_READ, 32'h2000000C, 32'h0, F3_W, 2, 32'hCAFEF00D,
                  st, ga, gb, gw, gwe, us, va, md, hg);
        checks++;
        if (md !== 32'hCAFEF00D || st !== 4) begin
            errors++; $display("FAIL lw_data got %h st %0d exp cafef00d 4", md, st);
        end

        do_access(ACC_READ, 32'h20000003, 32'h0, F3_HU, 0, 32'h80011234,
                  st, ga, gb, gw, gwe, us, va, md, hg);
        checks++;
        if (md !== 32'h00008001 || gb !== 4'b1100) begin
            errors++; $display("FAIL lhu_misalign got %h be %b exp 00008001 1100", md, gb);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] held;
        bit bad;
        held = w_data;
        bad = 0;
        w_mic_ctrl = F3_W;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       begin w_mic_req = ACC_READ;  w_mic_addr = 32'h10000040; end
                1:       begin w_mic_req = ACC_CODE;  w_mic_addr = 32'h20000000; end
                default: begin w_mic_req = ACC_WRITE; w_mic_addr = 32'h1000FFFC; end
            endcase
            bus_ready = (i == 1);
            bus_rdata = 32'h13579BDF;
            for (int c = 0; c < 3; c++) begin
                #1;
                if (w_stall !== 1'b0 || bus_valid !== 1'b0) bad = 1;
                tick();
            end
        end
        bus_ready = 1'b0;
        w_mic_req = ACC_NONE;
        tick();
        checks++;
        if (bad) begin errors++; $display("FAIL bypass_quiet got stall/valid high exp 0"); end
        checks++;
        if (w_data !== held) begin errors++; $display("FAIL bypass_data got %h exp %h", w_data, held); end
    endtask

    task automatic test_timeout();
        do_access(ACC_READ, 32'h20000010, 32'h0, F3_W, 100, 32'h0,
                  st, ga, gb, gw, gwe, us, va, md, hg);
        checks++;
        if (st !== 6 || hg) begin errors++; $display("FAIL to_stall got %0d exp 6", st); end
        checks++;
        if (md !== 32'hDEADBEEF) begin errors++; $display("FAIL to_data got %h exp deadbeef", md); end
        checks++;
        if (w_err !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", w_err); end

        do_access(ACC_WRITE, 32'h20000020, 32'h000000FF, F3_B, 0, 32'h0,
                  st, ga, gb, gw, gwe, us, va, md, hg);
        checks++;
        if (w_err !== 1'b1 || st !== 2) begin
            errors++; $display("FAIL to_sticky got err %b st %0d exp 1 2", w_err, st);
        end
    endtask

    task automatic test_reset_mid();
        w_mic_req = ACC_READ; w_mic_addr = 32'h20000014; w_mic_ctrl = F3_W; bus_ready = 1'b0;
        tick();
        checks++;
        if (bus_valid !== 1'b1) begin errors++; $display("FAIL mid_valid_up got %b exp 1", bus_valid); end
        tick();
        RST = 1'b1;
        tick();
        checks++;
        if (bus_valid !== 1'b0 || w_err !== 1'b0 || w_data !== 32'h0) begin
            errors++; $display("FAIL mid_abort got valid %b err %b data %h exp 0 0 0", bus_valid, w_err, w_data);
        end
        RST = 1'b0; w_mic_req = ACC_NONE;
        tick();
        tick();
        checks++;
        if (bus_valid !== 1'b0) begin errors++; $display("FAIL mid_idle got %b exp 0", bus_valid); end

        do_access(ACC_READ, 32'h20000018, 32'h0, F3_W, 1, 32'h0BADF00D,
                  st, ga, gb, gw, gwe, us, va, md, hg);
        checks++;
        if (st !== 3 || md !== 32'h0BADF00D || ga !== 32'h20000018) begin
            errors++; $display("FAIL mid_recover got st %0d data %h addr %h exp 3 0badf00d 20000018", st, md, ga);
        end
    endtask

    initial begin
        test_reset();
        test_stores();
        test_loads();
        test_bypass();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
